// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants, FSM state codes and address-mapping helpers for the
// MEM-stage SRAM controller.
package mem_sram_ctrl_pkg;

  localparam int SRAM_DATA_LEN = 16;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_WORD_LEN = SRAM_ADDR_LEN - 1;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LO   = 2'd1,
    SRAM_HI   = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_e;

  // 32-bit SRAM word index of a processor byte address, wrapping mod 2^17.
  function automatic logic [SRAM_WORD_LEN-1:0] sram_word(input logic [31:0] address,
                                                         input logic [31:0] base);
    return SRAM_WORD_LEN'((address - base) >> 2);
  endfunction

  // True when the address lies below the SRAM window or beyond its last word.
  function automatic logic sram_addr_bad(input logic [31:0] address,
                                         input logic [31:0] base);
    return (address < base) || (((address - base) >> (SRAM_WORD_LEN + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// MEM-stage load/store request bus: the MEM stage is the master, the SRAM
// controller the slave.
interface mem_sram_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output rd_en, wr_en, address, write_data,
                  input  read_data, ready);
  modport slave  (input  rd_en, wr_en, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/mem_sram_wait_cnt.sv
// Clearable up-counter that times each half-word access; o_last flags the
// final cycle of the WAIT_CYCLES-long window.
module mem_sram_wait_cnt #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst || i_clr) r_cnt <= '0;
    else if (i_en)     r_cnt <= r_cnt + CW'(1);
  end

  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/mem_sram_ctrl.sv
// 32-bit load/store responder for the MEM stage over a 16-bit async SRAM,
// split into low/high half-word accesses. Define SRAM_ADDR_CHECK_EN to add addr_err.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_sram_ctrl_if.slave           mem,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic                     addr_err
`endif
);

  sram_state_e              r_state, w_state_nxt;
  logic                     r_is_wr;
  logic [SRAM_WORD_LEN-1:0] r_word;
  logic [31:0]              r_wdata;
  logic [15:0]              r_rd_lo, r_rd_hi;
  logic                     w_req, w_busy, w_last, w_dq_oe;
  logic [15:0]              w_dq_out;

  assign w_req  = mem.rd_en | mem.wr_en;
  assign w_busy = (r_state == SRAM_LO) || (r_state == SRAM_HI);

  mem_sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (~w_busy | w_last),
    .i_en   (w_busy),
    .o_last (w_last)
  );

`ifdef SRAM_ADDR_CHECK_EN
  logic r_addr_err;
  logic w_bad;
  assign w_bad    = sram_addr_bad(mem.address, BASE_ADDR);
  assign addr_err = (r_state == SRAM_DONE) && r_addr_err;
`endif

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SRAM_IDLE: if (w_req) begin
`ifdef SRAM_ADDR_CHECK_EN
        w_state_nxt = w_bad ? SRAM_DONE : SRAM_LO;
`else
        w_state_nxt = SRAM_LO;
`endif
      end
      SRAM_LO:   if (w_last) w_state_nxt = SRAM_HI;
      SRAM_HI:   if (w_last) w_state_nxt = SRAM_DONE;
      SRAM_DONE: w_state_nxt = SRAM_IDLE;
      default:   w_state_nxt = SRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SRAM_IDLE;
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_rd_lo <= '0;
      r_rd_hi <= '0;
`ifdef SRAM_ADDR_CHECK_EN
      r_addr_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == SRAM_IDLE && w_req) begin
        r_is_wr <= mem.wr_en;
        r_word  <= sram_word(mem.address, BASE_ADDR);
        r_wdata <= mem.write_data;
`ifdef SRAM_ADDR_CHECK_EN
        r_addr_err <= w_bad;
`endif
      end
      // Loads sample the bus on the last cycle of each half, after the SRAM settles.
      if (r_state == SRAM_LO && w_last && !r_is_wr) r_rd_lo <= SRAM_DQ;
      if (r_state == SRAM_HI && w_last && !r_is_wr) r_rd_hi <= SRAM_DQ;
    end
  end

  // Write strobe drops on each half's last cycle to give address/data hold time.
  assign SRAM_ADDR = w_busy ? {r_word, (r_state == SRAM_HI)} : '0;
  assign SRAM_WE_N = ~(r_is_wr & w_busy & ~w_last);
  assign w_dq_oe   = r_is_wr & w_busy;
  assign w_dq_out  = (r_state == SRAM_HI) ? r_wdata[31:16] : r_wdata[15:0];
  assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign mem.read_data = {r_rd_hi, r_rd_lo};
  assign mem.ready     = ((r_state == SRAM_IDLE) && !w_req) || (r_state == SRAM_DONE);

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: WAIT_CYCLES=2 and WAIT_CYCLES=1 instances,
// each with a small behavioural SRAM on its pins.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  mem_sram_ctrl_if mif_a ();
  mem_sram_ctrl_if mif_b ();

  wire  [15:0] dq_a, dq_b;
  logic [17:0] addr_a, addr_b;
  logic        we_a, we_b;
  logic        ub_a, lb_a, ce_a, oe_a, ub_b, lb_b, ce_b, oe_b;
`ifdef SRAM_ADDR_CHECK_EN
  logic        err_a, err_b;
`endif

  mem_sram_ctrl #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut_a (
    .clk(clk), .rst(rst), .mem(mif_a.slave),
    .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a), .SRAM_WE_N(we_a),
    .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
`ifdef SRAM_ADDR_CHECK_EN
    , .addr_err(err_a)
`endif
  );

  mem_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut_b (
    .clk(clk), .rst(rst), .mem(mif_b.slave),
    .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b), .SRAM_WE_N(we_b),
    .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
`ifdef SRAM_ADDR_CHECK_EN
    , .addr_err(err_b)
`endif
  );

  // Behavioural SRAM on instance A: writes while WE_N is low, drives reads on request.
  logic [15:0] mem_a [0:31];
  logic        load_mode_a = 1'b0;
  always @(posedge clk) if (!we_a) mem_a[addr_a[4:0]] <= dq_a;
  assign dq_a = (load_mode_a && we_a) ? mem_a[addr_a[4:0]] : 16'bz;

  logic [17:0] addr_log [0:31];
  logic [15:0] dq_log   [0:31];
  logic        err_log  [0:31];
  int          we_lows;

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Issues one request (sel=0: A, sel=1: B), logs pins after every edge until ready.
  task automatic txn(input bit sel, input bit rd, input bit wr,
                     input logic [31:0] adr, input logic [31:0] dat, output int n);
    logic rdy;
    if (!sel) begin
      mif_a.rd_en = rd; mif_a.wr_en = wr; mif_a.address = adr; mif_a.write_data = dat;
      load_mode_a = rd & ~wr;
    end else begin
      mif_b.rd_en = rd; mif_b.wr_en = wr; mif_b.address = adr; mif_b.write_data = dat;
    end
    n = 0;
    we_lows = 0;
    do begin
      @(posedge clk);
      #1;
      rdy         = sel ? mif_b.ready : mif_a.ready;
      addr_log[n] = sel ? addr_b : addr_a;
      dq_log[n]   = sel ? dq_b : dq_a;
`ifdef SRAM_ADDR_CHECK_EN
      err_log[n]  = sel ? err_b : err_a;
`else
      err_log[n]  = 1'b0;
`endif
      if (!(sel ? we_b : we_a)) we_lows++;
      n++;
    end while (!rdy && n < 20);
    check("ready_reached", {31'd0, rdy}, 32'd1);
    mif_a.rd_en = 1'b0; mif_a.wr_en = 1'b0;
    mif_b.rd_en = 1'b0; mif_b.wr_en = 1'b0;
    load_mode_a = 1'b0;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 32; i++) mem_a[i] = 16'h0000;
    mif_a.rd_en = 0; mif_a.wr_en = 0; mif_a.address = 0; mif_a.write_data = 0;
    mif_b.rd_en = 0; mif_b.wr_en = 0; mif_b.address = 0; mif_b.write_data = 0;
    idle(3);
    rst = 1'b1;
    idle(1);

    // Reset state
    check("rst_ready",  {31'd0, mif_a.ready}, 32'd1);
    check("rst_rdata",  mif_a.read_data, 32'd0);
    check("rst_addr",   {14'd0, addr_a}, 32'd0);
    check("rst_we_n",   {31'd0, we_a}, 32'd1);
    check("tied_pins",  {28'd0, ub_a, lb_a, ce_a, oe_a}, 32'd0);

    // 1: store 0xDEADBEEF @1024, latency 5 edges from IDLE
    txn(0, 0, 1, 32'd1024, 32'hDEADBEEF, n);
    check("t1_latency", n, 32'd5);
    check("t1_lo_addr", {14'd0, addr_log[0]}, 32'd0);
    check("t1_hi_addr", {14'd0, addr_log[2]}, 32'd1);
    check("t1_lo_dq",   {16'd0, dq_log[0]}, 32'h0000BEEF);
    check("t1_hi_dq",   {16'd0, dq_log[2]}, 32'h0000DEAD);
    check("t1_we_lows", we_lows, 32'd2);
    check("t1_sram0",   {16'd0, mem_a[0]}, 32'h0000BEEF);
    check("t1_sram1",   {16'd0, mem_a[1]}, 32'h0000DEAD);
    check("t1_rdata_kept", mif_a.read_data, 32'd0);

    // 2: load @1024
    idle(2);
    txn(0, 1, 0, 32'd1024, 32'd0, n);
    check("t2_latency", n, 32'd5);
    check("t2_rdata",   mif_a.read_data, 32'hDEADBEEF);
    check("t2_we_lows", we_lows, 32'd0);
    check("t2_no_err",  {31'd0, err_log[4]}, 32'd0);

    // 3: store @1028, then back-to-back load (extra IDLE cycle after DONE)
    idle(2);
    txn(0, 0, 1, 32'd1028, 32'h12345678, n);
    check("t3_st_latency", n, 32'd5);
    check("t3_sram2", {16'd0, mem_a[2]}, 32'h00005678);
    check("t3_sram3", {16'd0, mem_a[3]}, 32'h00001234);
    txn(0, 1, 0, 32'd1028, 32'd0, n);
    check("t3_ld_latency", n, 32'd6);
    check("t3_idle_addr",  {14'd0, addr_log[0]}, 32'd0);
    check("t3_lo_addr",    {14'd0, addr_log[1]}, 32'd2);
    check("t3_hi_addr",    {14'd0, addr_log[3]}, 32'd3);
    check("t3_rdata",      mif_a.read_data, 32'h12345678);

    // 4: WAIT_CYCLES=1, rd&wr both set -> store; no WE_N pulse, data on the bus
    idle(2);
    txn(1, 1, 1, 32'd1032, 32'h0000A5A5, n);
    check("t4_latency", n, 32'd3);
    check("t4_lo_addr", {14'd0, addr_log[0]}, 32'd4);
    check("t4_hi_addr", {14'd0, addr_log[1]}, 32'd5);
    check("t4_lo_dq",   {16'd0, dq_log[0]}, 32'h0000A5A5);
    check("t4_hi_dq",   {16'd0, dq_log[1]}, 32'h00000000);
    check("t4_we_lows", we_lows, 32'd0);
    check("t4_rdata",   mif_b.read_data, 32'd0);

    // 5: reset during HI of a load, then a clean load
    idle(2);
    mif_a.rd_en = 1'b1; mif_a.address = 32'd1024; load_mode_a = 1'b1;
    idle(3);
    check("t5_in_hi_addr", {14'd0, addr_a}, 32'd1);
    check("t5_lo_captured", mif_a.read_data, 32'h1234BEEF);
    rst = 1'b0; mif_a.rd_en = 1'b0; load_mode_a = 1'b0;
    idle(1);
    check("t5_rst_rdata", mif_a.read_data, 32'd0);
    check("t5_rst_we_n",  {31'd0, we_a}, 32'd1);
    check("t5_rst_addr",  {14'd0, addr_a}, 32'd0);
    check("t5_rst_ready", {31'd0, mif_a.ready}, 32'd1);
    rst = 1'b1;
    idle(1);
    txn(0, 1, 0, 32'd1024, 32'd0, n);
    check("t5_latency", n, 32'd5);
    check("t5_rdata",   mif_a.read_data, 32'hDEADBEEF);

`ifdef SRAM_ADDR_CHECK_EN
    // 6: out-of-window load goes straight to DONE with addr_err
    idle(2);
    txn(0, 1, 0, 32'd512, 32'd0, n);
    check("t6_latency", n, 32'd1);
    check("t6_err",     {31'd0, err_log[0]}, 32'd1);
    check("t6_addr",    {14'd0, addr_log[0]}, 32'd0);
    check("t6_we_lows", we_lows, 32'd0);
    check("t6_rdata",   mif_a.read_data, 32'hDEADBEEF);
    idle(1);
    check("t6_err_clr", {31'd0, err_a}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
